// File: rtl/decode_queue.sv
// Multi-lane IF->ID instruction buffer with push-time predecode.
// Fetch pushes up to FETCH_W entries; decode sees the oldest DEC_W entries.
module decode_queue #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int DEC_W   = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int FC_W   = $clog2(FETCH_W + 1),
    localparam int DA_W   = $clog2(DEC_W + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [FC_W-1:0]      fetch_cnt,
    input  logic [FETCH_W*32-1:0] fetch_pc,
    input  logic [FETCH_W*32-1:0] fetch_instr,
    input  logic [FETCH_W-1:0]   fetch_excp,
    output logic [DEC_W-1:0]     dec_valid,
    output logic [DEC_W*32-1:0]  dec_pc,
    output logic [DEC_W*32-1:0]  dec_instr,
    output logic [DEC_W-1:0]     dec_excp,
    output logic [DEC_W*3-1:0]   dec_class,
    input  logic [DA_W-1:0]      dec_accept,
    output logic [CNT_W-1:0]     occupancy,
    output logic                 err_overpop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic             excp_q  [DEPTH];
    logic [2:0]       class_q [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count, push_n, pop_n;
    logic             push_en, overpop;

    // First matching rule wins; order encodes the class priority.
    function automatic logic [2:0] predecode(input logic [31:0] ins);
        logic [2:0] c;
        c = 3'd0;
        if (ins[31:15] == 17'h00056 || ins[31:15] == 17'h00054)
            c = 3'd5;
        else if (ins[31:24] == 8'h04 || ins[31:20] == 12'h064)
            c = 3'd4;
        else if (ins[31:30] == 2'b01)
            c = 3'd3;
        else if (ins[31:26] == 6'b001010) begin
            if (ins[25:22] inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9})
                c = 3'd1;
            else if (ins[25:22] inside {4'd4, 4'd5, 4'd6})
                c = 3'd2;
        end
        return c;
    endfunction

    assign fetch_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
    assign push_en     = fetch_valid && fetch_ready && !flush;
    assign push_n      = push_en ? CNT_W'(fetch_cnt) : '0;
    assign overpop     = CNT_W'(dec_accept) > count;
    assign pop_n       = overpop ? count : CNT_W'(dec_accept);
    assign occupancy   = count;

    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (i < int'(fetch_cnt)) begin
                    pc_q[tail + PTR_W'(i)]    <= fetch_pc[32*i +: 32];
                    instr_q[tail + PTR_W'(i)] <= fetch_instr[32*i +: 32];
                    excp_q[tail + PTR_W'(i)]  <= fetch_excp[i];
                    class_q[tail + PTR_W'(i)] <= fetch_excp[i] ? 3'd0
                        : predecode(fetch_instr[32*i +: 32]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            err_overpop <= 1'b0;
        end else begin
            if (overpop)
                err_overpop <= 1'b1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PTR_W'(pop_n);
                tail  <= tail + PTR_W'(push_n);
                count <= count + push_n - pop_n;
            end
        end
    end

    always_comb begin
        dec_valid = '0;
        dec_pc    = '0;
        dec_instr = '0;
        dec_excp  = '0;
        dec_class = '0;
        for (int i = 0; i < DEC_W; i++) begin
            dec_valid[i]         = CNT_W'(i) < count;
            dec_pc[32*i +: 32]    = pc_q[head + PTR_W'(i)];
            dec_instr[32*i +: 32] = instr_q[head + PTR_W'(i)];
            dec_excp[i]          = excp_q[head + PTR_W'(i)];
            dec_class[3*i +: 3]  = class_q[head + PTR_W'(i)];
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: driver queues expected entries,
// a negedge monitor compares the decode window and pops on acceptance.
module tb_decode_queue;
    localparam int DEPTH = 8;
    localparam int FW    = 2;
    localparam int DW    = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [1:0]  fetch_cnt = '0;
    logic [63:0] fetch_pc = '0;
    logic [63:0] fetch_instr = '0;
    logic [1:0]  fetch_excp = '0;
    logic [1:0]  dec_valid;
    logic [63:0] dec_pc;
    logic [63:0] dec_instr;
    logic [1:0]  dec_excp;
    logic [5:0]  dec_class;
    logic [1:0]  dec_accept = '0;
    logic [3:0]  occupancy;
    logic        err_overpop;

    decode_queue #(.DEPTH(DEPTH), .FETCH_W(FW), .DEC_W(DW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_cnt(fetch_cnt), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .fetch_excp(fetch_excp),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr),
        .dec_excp(dec_excp), .dec_class(dec_class),
        .dec_accept(dec_accept), .occupancy(occupancy),
        .err_overpop(err_overpop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
        logic [2:0]  cls;
    } ent_t;

    ent_t q[$];
    ent_t pend[$];
    int checks = 0;
    int failures = 0;
    int mcount = 0;
    logic m_ovp = 1'b0;
    int n, vis, npop;
    logic [31:0] pc_ctr = 32'h1c00_0000;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [31:0] ins,
                                             input logic ex);
        int op6, sub;
        op6 = int'(ins >> 26);
        sub = int'((ins >> 22) & 32'hF);
        if (ex) return 3'd0;
        if ((ins >> 15) == 32'h56 || (ins >> 15) == 32'h54) return 3'd5;
        if ((ins >> 24) == 32'h04 || (ins >> 20) == 32'h064) return 3'd4;
        if ((ins >> 30) == 32'h1) return 3'd3;
        if (op6 == 10 && sub inside {0, 1, 2, 8, 9}) return 3'd1;
        if (op6 == 10 && sub inside {4, 5, 6}) return 3'd2;
        return 3'd0;
    endfunction

    always @(posedge clk)
        if (resetn && fetch_valid)
            assert (fetch_cnt <= 2'(FW)) else $error("fetch_cnt too large");

    // Driver: applies one cycle of stimulus, predicts pushes from its own count.
    task automatic drive(input logic v, input int cnt,
                         input logic [31:0] p0, input logic [31:0] i0,
                         input logic [31:0] p1, input logic [31:0] i1,
                         input logic [1:0] ex, input int acc,
                         input logic fl);
        ent_t e;
        logic push;
        int pop;
        fetch_valid = v;
        fetch_cnt   = 2'(cnt);
        fetch_pc    = {p1, p0};
        fetch_instr = {i1, i0};
        fetch_excp  = ex;
        dec_accept  = 2'(acc);
        flush       = fl;
        push = v && (DEPTH - mcount >= FW) && !fl;
        if (push) begin
            for (int i = 0; i < cnt; i++) begin
                e.pc    = (i == 0) ? p0 : p1;
                e.instr = (i == 0) ? i0 : i1;
                e.excp  = ex[i];
                e.cls   = ref_class(e.instr, e.excp);
                pend.push_back(e);
            end
        end
        pop = (acc < mcount) ? acc : mcount;
        mcount = fl ? 0 : mcount + (push ? cnt : 0) - pop;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int acc);
        drive(1'b0, 0, 0, 0, 0, 0, 2'b00, acc, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && mcount > 0; k++)
            idle(mcount < 2 ? mcount : 2);
    endtask

    function automatic logic [31:0] pick_instr();
        case ($urandom_range(0, 9))
            0: return 32'h0280_0421;
            1: return 32'h2880_0000;
            2: return 32'h2980_0000;
            3: return 32'h002B_0000;
            4: return 32'h002A_0000;
            5: return 32'h0400_0401;
            6: return 32'h0648_0000;
            7: return 32'h4C00_0000;
            8: return 32'h2A00_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_cycles(input int ncyc);
        int cnt, acc, lim;
        logic [31:0] pa;
        for (int k = 0; k < ncyc; k++) begin
            cnt = $urandom_range(0, 2);
            lim = mcount < 2 ? mcount : 2;
            acc = $urandom_range(0, lim);
            pa = pc_ctr;
            pc_ctr += 8;
            drive(1'($urandom_range(0, 3) != 0), cnt, pa, pick_instr(),
                  pa + 4, pick_instr(), 2'($urandom_range(0, 3)),
                  acc, 1'($urandom_range(0, 15) == 0));
        end
    endtask

    // Monitor: compares the visible decode window with the scoreboard queue.
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_occupancy", 32'(occupancy), 0);
            chk("rst_dec_valid", 32'(dec_valid), 0);
            chk("rst_fetch_ready", 32'(fetch_ready), 1);
            chk("rst_err_overpop", 32'(err_overpop), 0);
            q.delete();
            pend.delete();
            m_ovp = 1'b0;
        end else begin
            n   = q.size();
            vis = (n < DW) ? n : DW;
            chk("occupancy", 32'(occupancy), n);
            chk("fetch_ready", 32'(fetch_ready), (DEPTH - n) >= FW);
            chk("dec_valid", 32'(dec_valid), (1 << vis) - 1);
            chk("err_overpop", 32'(err_overpop), 32'(m_ovp));
            for (int i = 0; i < vis; i++) begin
                chk("dec_pc", dec_pc[32*i +: 32], q[i].pc);
                chk("dec_instr", dec_instr[32*i +: 32], q[i].instr);
                chk("dec_excp", 32'(dec_excp[i]), 32'(q[i].excp));
                chk("dec_class", 32'(dec_class[3*i +: 3]), 32'(q[i].cls));
            end
            if (int'(dec_accept) > n) m_ovp = 1'b1;
            npop = (int'(dec_accept) < n) ? int'(dec_accept) : n;
            if (flush) begin
                q.delete();
            end else begin
                repeat (npop) void'(q.pop_front());
                foreach (pend[j]) q.push_back(pend[j]);
            end
            pend.delete();
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        drive(1, 2, 32'h1c00_0000, 32'h0280_0421,
              32'h1c00_0004, 32'h2880_0000, 2'b00, 0, 0);
        chk("t1_dec_valid", 32'(dec_valid), 32'h3);
        chk("t1_dec_class", 32'(dec_class), 32'({3'd1, 3'd0}));
        chk("t1_occupancy", 32'(occupancy), 2);
        drain();

        for (int k = 0; k < 4; k++) begin
            drive(1, 2, pc_ctr, pick_instr(), pc_ctr + 4, pick_instr(),
                  2'b00, 0, 0);
            pc_ctr += 8;
        end
        chk("t2_full_occ", 32'(occupancy), 8);
        chk("t2_full_ready", 32'(fetch_ready), 0);
        idle(2);
        chk("t2_occ", 32'(occupancy), 6);
        chk("t2_ready", 32'(fetch_ready), 1);

        drive(1, 1, pc_ctr, pick_instr(), 0, 0, 2'b00, 0, 0);
        pc_ctr += 4;
        drive(1, 1, pc_ctr, pick_instr(), 0, 0, 2'b00, 2, 0);
        pc_ctr += 4;
        chk("t3_occ", 32'(occupancy), 5);
        drain();

        drive(1, 2, 32'h1c00_0100, 32'h002B_0000,
              32'h1c00_0104, 32'h0400_0401, 2'b00, 0, 0);
        chk("t4_class", 32'(dec_class), 32'({3'd4, 3'd5}));
        drive(1, 2, 32'h1c00_0100, 32'h002B_0000,
              32'h1c00_0104, 32'h0400_0401, 2'b11, 2, 0);
        chk("t4_excp_class", 32'(dec_class), 0);
        chk("t4_excp", 32'(dec_excp), 32'h3);
        drain();

        drive(1, 2, pc_ctr, pick_instr(), pc_ctr + 4, pick_instr(), 2'b00, 0, 0);
        drive(1, 2, pc_ctr, pick_instr(), pc_ctr + 4, pick_instr(), 2'b00, 0, 0);
        drive(1, 1, pc_ctr, pick_instr(), 0, 0, 2'b00, 0, 0);
        chk("t5_pre_occ", 32'(occupancy), 5);
        drive(1, 2, pc_ctr, pick_instr(), pc_ctr + 4, pick_instr(), 2'b00, 2, 1);
        chk("t5_occ", 32'(occupancy), 0);
        chk("t5_valid", 32'(dec_valid), 0);

        drive(1, 1, 32'h1c00_0200, 32'h4C00_0000, 0, 0, 2'b00, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 2'b00, 2, 0);
        mcount = 0;
        chk("t6_err", 32'(err_overpop), 1);
        chk("t6_occ", 32'(occupancy), 0);
        idle(0);
        chk("t6_err_sticky", 32'(err_overpop), 1);

        rand_cycles(30);
        idle(0);
        resetn = 1'b0;
        #1;
        chk("mid_rst_occ", 32'(occupancy), 0);
        chk("mid_rst_valid", 32'(dec_valid), 0);
        chk("mid_rst_err", 32'(err_overpop), 0);
        mcount = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        rand_cycles(40);
        drain();
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
